// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control: opcodes, FSM states,
// ALUOp classes and the packed control word handed from decoder to top.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [3:0] ALUOP_ADD   = 4'd0;
  localparam logic [3:0] ALUOP_SUB   = 4'd1;
  localparam logic [3:0] ALUOP_FUNCT = 4'd2;
  localparam logic [3:0] ALUOP_ADDI  = 4'd3;
  localparam logic [3:0] ALUOP_SLTI  = 4'd4;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_IMM_EXEC  = 4'd10,
    S_IMM_WB    = 4'd11
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
    logic [1:0] pc_source;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/mc_output_decode.sv
// Combinational Moore decode of the registered state into the datapath control word.
// Only IMM_EXEC looks at the opcode; only FETCH lets mem_ready reach an enable.
module mc_output_decode
  import mips_ctrl_pkg::*;
(
  input  state_t      state_i,
  input  logic [5:0]  op_i,
  input  logic        mem_ready_i,
  output ctrl_t       ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = 2'b01;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b = 2'b11;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_MEM_ADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = 2'b10;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_MEM_READ: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_write  = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.i_or_d    = 1'b1;
      end
      S_EXECUTE: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_op        = ALUOP_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = 2'b01;
      end
      S_JUMP: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = 2'b10;
      end
      S_IMM_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = 2'b10;
        ctrl_o.alu_op    = (op_i == OP_ADDI) ? ALUOP_ADDI : ALUOP_SLTI;
      end
      S_IMM_WB: begin
        ctrl_o.reg_write = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_main_control.sv
// Main control FSM of the multicycle MIPS datapath; memory states stall on mem_ready.
// Write enables are masked combinationally by reset so an abort needs no clock edge.
module multicycle_main_control
  import mips_ctrl_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] PCSource,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUOp,
  output logic [3:0] state,
  output logic       illegal_op,
  output logic       instr_done
);

  state_t state_q, state_d;
  logic   illegal_op_q, illegal_op_d;
  logic   instr_done_q, instr_done_d;
  logic   ready;
  ctrl_t  ctrl;

  assign ready = MEM_WAIT_EN ? mem_ready : 1'b1;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:     if (ready) state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_RTYPE:         state_d = S_EXECUTE;
          OP_LW, OP_SW:     state_d = S_MEM_ADDR;
          OP_BEQ:           state_d = S_BRANCH;
          OP_J:             state_d = S_JUMP;
          OP_ADDI, OP_SLTI: state_d = S_IMM_EXEC;
          default:          state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR: begin
        if (Op == OP_LW)      state_d = S_MEM_READ;
        else if (Op == OP_SW) state_d = S_MEM_WRITE;
        else                  state_d = S_FETCH;
      end
      S_MEM_READ:  if (ready) state_d = S_MEM_WB;
      S_MEM_WRITE: if (ready) state_d = S_FETCH;
      S_EXECUTE:   state_d = S_R_WB;
      S_IMM_EXEC:  state_d = S_IMM_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_IMM_WB: state_d = S_FETCH;
      default:     state_d = S_FETCH;
    endcase
  end

  // Only genuine retirements pulse instr_done; DECODE fallthrough and stray encodings do not.
  always_comb begin
    illegal_op_d = (state_q == S_DECODE) && (state_d == S_FETCH);
    instr_done_d = (state_d == S_FETCH) &&
                   (state_q inside {S_MEM_WB, S_MEM_WRITE, S_R_WB, S_BRANCH, S_JUMP, S_IMM_WB});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_FETCH;
      illegal_op_q <= 1'b0;
      instr_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      illegal_op_q <= illegal_op_d;
      instr_done_q <= instr_done_d;
    end
  end

  mc_output_decode u_decode (
    .state_i     (state_q),
    .op_i        (Op),
    .mem_ready_i (ready),
    .ctrl_o      (ctrl)
  );

  assign PCWrite     = ctrl.pc_write      & ~reset;
  assign PCWriteCond = ctrl.pc_write_cond & ~reset;
  assign IRWrite     = ctrl.ir_write      & ~reset;
  assign RegWrite    = ctrl.reg_write     & ~reset;
  assign MemWrite    = ctrl.mem_write     & ~reset;
  assign IorD        = ctrl.i_or_d;
  assign MemRead     = ctrl.mem_read;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign RegDst      = ctrl.reg_dst;
  assign PCSource    = ctrl.pc_source;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ALUOp       = ctrl.alu_op;
  assign state       = state_q;
  assign illegal_op  = illegal_op_q;
  assign instr_done  = instr_done_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Scoreboarded bench for multicycle_main_control: each cycle pushes the expected
// state/control word/pulses, the negedge sample pops and compares.
module tb_multicycle_main_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Op;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, ALUSrcA, RegWrite, RegDst;
  logic [1:0] PCSource, ALUSrcB;
  logic [3:0] ALUOp, state;
  logic       illegal_op, instr_done;

  multicycle_main_control #(.MEM_WAIT_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .Op(Op), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA),
    .RegWrite(RegWrite), .RegDst(RegDst), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .state(state), .illegal_op(illegal_op), .instr_done(instr_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  st;
    logic [17:0] word;
    logic        done;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic pend_done = 1'b0;
  logic pend_ill  = 1'b0;

  wire [17:0] obs_word = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                          IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic logic [17:0] exp_word(input logic [3:0] st, input logic [5:0] op,
                                           input logic rdy, input logic rst);
    logic pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd;
    logic [1:0] pcs, asb;
    logic [3:0] aop;
    {pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd} = '0;
    pcs = 2'b00; asb = 2'b00; aop = 4'd0;
    case (st)
      4'd0:  begin mrd = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
      4'd1:  asb = 2'b11;
      4'd2:  begin asa = 1; asb = 2'b10; end
      4'd3:  begin mrd = 1; iord = 1; end
      4'd4:  begin m2r = 1; rw = 1; end
      4'd5:  begin mwr = 1; iord = 1; end
      4'd6:  begin asa = 1; aop = 4'd2; end
      4'd7:  begin rd = 1; rw = 1; end
      4'd8:  begin asa = 1; aop = 4'd1; pcwc = 1; pcs = 2'b01; end
      4'd9:  begin pcw = 1; pcs = 2'b10; end
      4'd10: begin asa = 1; asb = 2'b10; aop = (op == 6'd8) ? 4'd3 : 4'd4; end
      4'd11: rw = 1;
      default: ;
    endcase
    if (rst) {pcw, pcwc, irw, rw, mwr} = '0;
    return {pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd, pcs, asb, aop};
  endfunction

  // Called shortly after a rising edge; samples at the following falling edge.
  task automatic step(input logic [3:0] st, input logic rdy);
    exp_t e;
    mem_ready = rdy;
    exp_q.push_back('{st: st, word: exp_word(st, Op, rdy, reset), done: pend_done, ill: pend_ill});
    pend_done = 1'b0;
    pend_ill  = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    check_eq($sformatf("state(exp %0d)", e.st), {28'd0, state}, {28'd0, e.st});
    check_eq($sformatf("ctrl_word(st %0d op %0d)", e.st, Op), {14'd0, obs_word}, {14'd0, e.word});
    check_eq($sformatf("instr_done(st %0d)", e.st), {31'd0, instr_done}, {31'd0, e.done});
    check_eq($sformatf("illegal_op(st %0d)", e.st), {31'd0, illegal_op}, {31'd0, e.ill});
    @(posedge clk);
    #1;
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic run_instr(input logic [5:0] op, input int fetch_stall, input int mem_stall);
    Op = op;
    for (int i = 0; i < fetch_stall; i++) step(4'd0, 1'b0);
    step(4'd0, 1'b1);
    step(4'd1, rnd_bit());
    case (op)
      6'd0:  begin step(4'd6, rnd_bit()); step(4'd7, rnd_bit()); pend_done = 1'b1; end
      6'd35: begin
        step(4'd2, rnd_bit());
        for (int i = 0; i < mem_stall; i++) step(4'd3, 1'b0);
        step(4'd3, 1'b1);
        step(4'd4, rnd_bit());
        pend_done = 1'b1;
      end
      6'd43: begin
        step(4'd2, rnd_bit());
        for (int i = 0; i < mem_stall; i++) step(4'd5, 1'b0);
        step(4'd5, 1'b1);
        pend_done = 1'b1;
      end
      6'd4:  begin step(4'd8, rnd_bit()); pend_done = 1'b1; end
      6'd2:  begin step(4'd9, rnd_bit()); pend_done = 1'b1; end
      6'd8, 6'd10: begin step(4'd10, rnd_bit()); step(4'd11, rnd_bit()); pend_done = 1'b1; end
      default: pend_ill = 1'b1;
    endcase
  endtask

  initial begin
    reset = 1'b0;
    Op = 6'd0;
    mem_ready = 1'b1;
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    step(4'd0, 1'b1);
    step(4'd0, 1'b1);
    reset = 1'b0;

    run_instr(6'd0, 0, 0);
    run_instr(6'd35, 1, 3);
    run_instr(6'd43, 0, 0);
    run_instr(6'd4, 0, 0);
    run_instr(6'd2, 0, 0);
    run_instr(6'd8, 0, 0);
    run_instr(6'd10, 0, 0);
    run_instr(6'd63, 0, 0);
    run_instr(6'd43, 0, 2);
    run_instr(6'd0, 0, 0);

    // Abort a store while it is stalled in MEM_WRITE.
    Op = 6'd43;
    step(4'd0, 1'b1);
    step(4'd1, 1'b1);
    step(4'd2, 1'b1);
    step(4'd5, 1'b0);
    reset = 1'b1;
    pend_done = 1'b0;
    pend_ill  = 1'b0;
    step(4'd0, 1'b1);
    reset = 1'b0;
    run_instr(6'd0, 0, 0);

    for (int k = 0; k < 20; k++) begin
      case ($urandom_range(0, 7))
        0: run_instr(6'd0, 0, 0);
        1: run_instr(6'd35, $urandom_range(0, 2), $urandom_range(0, 3));
        2: run_instr(6'd43, $urandom_range(0, 2), $urandom_range(0, 3));
        3: run_instr(6'd4, 0, 0);
        4: run_instr(6'd2, 0, 0);
        5: run_instr(6'd8, 0, 0);
        6: run_instr(6'd10, 0, 0);
        default: run_instr(6'd17, 0, 0);
      endcase
    end
    step(4'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
